// File: rtl/pc_seq_unit.sv
// rtl/pc_seq_unit.sv - program-counter sequencer with branch evaluation and optional return-address stack
// Optional feature macro: PC_RAS_EN (return-address stack); default build has no stack.
module pc_seq_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      ALIGN     = 2,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic [2:0]       pc_source,
    input  logic [2:0]       br_mode,
    input  logic             zero,
    input  logic             sign,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] jaddr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic             link,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_prev,
    output logic             br_taken,
    output logic             misalign,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam logic [2:0] SRC_ALU = 3'd0;
    localparam logic [2:0] SRC_BR  = 3'd1;
    localparam logic [2:0] SRC_J   = 3'd2;
    localparam logic [2:0] SRC_JR  = 3'd3;
    localparam logic [2:0] SRC_RAS = 3'd4;
    localparam logic [2:0] SRC_RST = 3'd5;

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~({WIDTH{1'b1}} << ALIGN);

    logic             en;
    logic             load;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_val;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_avail;

    always_comb begin
        br_taken = 1'b0;
        case (br_mode)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
            3'b010:  br_taken = sign;
            3'b011:  br_taken = ~sign;
            3'b100:  br_taken = sign | zero;
            3'b101:  br_taken = ~sign & ~zero;
            default: br_taken = 1'b0;
        endcase
    end

    assign en = pc_write | (pc_write_cond & br_taken);

    // sel_valid low means the selected source is a hold: no load, no push, no misalign
    always_comb begin
        sel_val   = pc;
        sel_valid = 1'b0;
        case (pc_source)
            SRC_ALU: begin sel_val = alu_result; sel_valid = 1'b1;      end
            SRC_BR:  begin sel_val = alu_out;    sel_valid = br_taken;  end
            SRC_J:   begin sel_val = jaddr;      sel_valid = 1'b1;      end
            SRC_JR:  begin sel_val = rs_data;    sel_valid = 1'b1;      end
            SRC_RAS: begin sel_val = ras_top;    sel_valid = ras_avail; end
            SRC_RST: begin sel_val = RESET_VEC;  sel_valid = 1'b1;      end
            default: begin sel_val = pc;         sel_valid = 1'b0;      end
        endcase
    end

    assign load    = en & sel_valid;
    assign next_pc = sel_val & ~ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VEC;
            pc_prev  <= RESET_VEC;
            misalign <= 1'b0;
        end else begin
            misalign <= load & (|(sel_val & ALIGN_MASK));
            if (load) begin
                pc <= next_pc;
                if (next_pc != pc) begin
                    pc_prev <= pc;
                end
            end
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned      PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W:0]   cnt;
    logic [PTR_W:0]   cnt_nxt;
    logic             push;
    logic             pop;
    logic             pop_empty;

    // sp is the next free slot; wrapping it on a full push overwrites the oldest entry
    assign top_idx   = sp - PTR_W'(1);
    assign ras_top   = ras_mem[top_idx];
    assign ras_avail = ~ras_empty;
    assign push      = load & link;
    assign pop       = load & (pc_source == SRC_RAS);
    assign pop_empty = en & (pc_source == SRC_RAS) & ras_empty;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop && (cnt != DEPTH_C)) begin
            cnt_nxt = cnt + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            cnt_nxt = cnt - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[pop ? top_idx : sp] <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            cnt       <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
            ras_err   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            ras_empty <= (cnt_nxt == '0);
            ras_full  <= (cnt_nxt == DEPTH_C);
            if (push && !pop) begin
                sp <= sp + PTR_W'(1);
            end else if (pop && !push) begin
                sp <= top_idx;
            end
            if ((push && !pop && (cnt == DEPTH_C)) || pop_empty) begin
                ras_err <= 1'b1;
            end
        end
    end
`else
    logic unused_ras;

    assign ras_top    = '0;
    assign ras_avail  = 1'b0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_err    = 1'b0;
    assign unused_ras = link | (RAS_DEPTH == 0);
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb/tb_pc_seq_unit.sv - self-checking bench for pc_seq_unit against a queue-based reference model
module tb_pc_seq_unit;

    localparam int W = 32;
    localparam int DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit HAS_RAS = 1'b1;
`else
    localparam bit HAS_RAS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pc_write = 1'b0;
    logic         pc_write_cond = 1'b0;
    logic [2:0]   pc_source = 3'd0;
    logic [2:0]   br_mode = 3'd0;
    logic         zero = 1'b0;
    logic         sign = 1'b0;
    logic [W-1:0] alu_result = '0;
    logic [W-1:0] alu_out = '0;
    logic [W-1:0] jaddr = '0;
    logic [W-1:0] rs_data = '0;
    logic         link = 1'b0;
    logic [W-1:0] pc;
    logic [W-1:0] pc_prev;
    logic         br_taken;
    logic         misalign;
    logic         ras_empty;
    logic         ras_full;
    logic         ras_err;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_pc;
    logic [W-1:0] m_prev;
    logic         m_mis;
    logic         m_err;
    logic [W-1:0] m_stk [$];

    pc_seq_unit dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .br_mode(br_mode), .zero(zero), .sign(sign),
        .alu_result(alu_result), .alu_out(alu_out), .jaddr(jaddr), .rs_data(rs_data),
        .link(link), .pc(pc), .pc_prev(pc_prev), .br_taken(br_taken), .misalign(misalign),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    // branch rules read as comparisons of the ALU result against zero
    function automatic logic ref_taken(input logic [2:0] mode, input logic z, input logic s);
        logic is_zero, is_neg;
        is_zero = z;
        is_neg  = s;
        case (mode)
            3'd0: return is_zero;
            3'd1: return !is_zero;
            3'd2: return is_neg;
            3'd3: return !is_neg;
            3'd4: return is_neg || is_zero;
            3'd5: return !is_neg && !is_zero;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input logic r, input logic pw, input logic pwc, input logic [2:0] src,
                        input logic [2:0] bm, input logic z, input logic s, input logic lk,
                        input logic [W-1:0] ar, input logic [W-1:0] ao,
                        input logic [W-1:0] ja, input logic [W-1:0] rd);
        logic tk, en, have;
        logic [W-1:0] val, nv;
        rst = r; pc_write = pw; pc_write_cond = pwc; pc_source = src; br_mode = bm;
        zero = z; sign = s; link = lk; alu_result = ar; alu_out = ao; jaddr = ja; rs_data = rd;
        if (r) begin
            m_pc = '0; m_prev = '0; m_mis = 1'b0; m_err = 1'b0;
            m_stk.delete();
        end else begin
            tk = ref_taken(bm, z, s);
            en = pw || (pwc && tk);
            have = 1'b0;
            val = '0;
            if (en) begin
                case (src)
                    3'd0: begin val = ar; have = 1'b1; end
                    3'd1: begin val = ao; have = tk; end
                    3'd2: begin val = ja; have = 1'b1; end
                    3'd3: begin val = rd; have = 1'b1; end
                    3'd4: if (HAS_RAS) begin
                        if (m_stk.size() > 0) begin
                            val = m_stk.pop_back();
                            have = 1'b1;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                    3'd5: begin val = '0; have = 1'b1; end
                    default: have = 1'b0;
                endcase
            end
            m_mis = 1'b0;
            if (have) begin
                nv = val - (val % 4);
                m_mis = (val % 4) != 0;
                if (HAS_RAS && lk) begin
                    m_stk.push_back(m_pc);
                    if (m_stk.size() > DEPTH) begin
                        void'(m_stk.pop_front());
                        m_err = 1'b1;
                    end
                end
                if (nv != m_pc) m_prev = m_pc;
                m_pc = nv;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 1, 3'd2, 3'd0, 1, 0, 1, 32'h4, 32'h8, 32'hC, 32'h10);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        checks++; if (pc_prev !== 32'h0) begin errors++; $display("FAIL reset_prev got %h want %h", pc_prev, 32'h0); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
            errors++; $display("FAIL reset_ras got e=%b f=%b err=%b want 1 0 0", ras_empty, ras_full, ras_err);
        end
    endtask

    task automatic test_basic();
        step(0, 1, 0, 3'd0, 3'd6, 0, 0, 0, 32'h4, 0, 0, 0);
        checks++; if (pc !== 32'h4 || pc_prev !== 32'h0) begin
            errors++; $display("FAIL basic_inc got pc=%h prev=%h want 4 0", pc, pc_prev);
        end
        step(0, 1, 0, 3'd0, 3'd6, 0, 0, 0, 32'h8, 0, 0, 0);
        step(0, 1, 0, 3'd0, 3'd6, 0, 0, 0, 32'hFFFF_FFFC + 32'h4, 0, 0, 0);
        checks++; if (pc !== 32'h0 || pc_prev !== 32'h8) begin
            errors++; $display("FAIL basic_wrap got pc=%h prev=%h want 0 8", pc, pc_prev);
        end
        step(0, 1, 0, 3'd2, 3'd6, 0, 0, 0, 0, 0, 32'h240, 0);
        step(1, 1, 0, 3'd2, 3'd6, 0, 0, 0, 0, 0, 32'h500, 0);
        checks++; if (pc !== 32'h0 || pc_prev !== 32'h0) begin
            errors++; $display("FAIL basic_midrst got pc=%h prev=%h want 0 0", pc, pc_prev);
        end
    endtask

    task automatic test_branch_sweep();
        logic tk;
        for (int m = 0; m < 8; m++) begin
            for (int c = 0; c < 4; c++) begin
                step(0, 1, 0, 3'd2, 3'd6, 0, 0, 0, 0, 0, 32'h100, 0);
                br_mode = 3'(m); zero = c[0]; sign = c[1];
                #1;
                tk = ref_taken(3'(m), c[0], c[1]);
                checks++; if (br_taken !== tk) begin
                    errors++; $display("FAIL br_taken mode=%0d z=%0d s=%0d got %b want %b", m, c[0], c[1], br_taken, tk);
                end
                step(0, 0, 1, 3'd1, 3'(m), c[0], c[1], 0, 0, 32'h40, 0, 0);
                checks++; if (pc !== (tk ? 32'h40 : 32'h100)) begin
                    errors++; $display("FAIL br_pc mode=%0d z=%0d s=%0d got %h want %h", m, c[0], c[1], pc, tk ? 32'h40 : 32'h100);
                end
            end
        end
    endtask

    task automatic test_misalign();
        step(0, 1, 0, 3'd3, 3'd6, 0, 0, 0, 0, 0, 0, 32'h1003);
        checks++; if (pc !== 32'h1000 || misalign !== 1'b1) begin
            errors++; $display("FAIL misalign_set got pc=%h mis=%b want 1000 1", pc, misalign);
        end
        step(0, 1, 0, 3'd6, 3'd6, 0, 0, 0, 32'h7, 32'h7, 32'h7, 32'h7);
        checks++; if (pc !== 32'h1000 || misalign !== 1'b0) begin
            errors++; $display("FAIL misalign_hold got pc=%h mis=%b want 1000 0", pc, misalign);
        end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras();
        logic [W-1:0] want;
        step(1, 0, 0, 3'd0, 3'd6, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 3'd2, 3'd6, 0, 0, 0, 0, 0, 32'h10, 0);
        step(0, 1, 0, 3'd2, 3'd6, 0, 0, 1, 0, 0, 32'h80, 0);
        checks++; if (pc !== 32'h80 || ras_empty !== 1'b0) begin
            errors++; $display("FAIL ras_jal got pc=%h empty=%b want 80 0", pc, ras_empty);
        end
        step(0, 1, 0, 3'd4, 3'd6, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (pc !== 32'h10 || ras_empty !== 1'b1) begin
            errors++; $display("FAIL ras_ret got pc=%h empty=%b want 10 1", pc, ras_empty);
        end
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 3'd2, 3'd6, 0, 0, 1, 0, 0, W'(i * 32'h100), 0);
        checks++; if (ras_full !== 1'b1 || ras_err !== 1'b1) begin
            errors++; $display("FAIL ras_overflow got full=%b err=%b want 1 1", ras_full, ras_err);
        end
        for (int i = 4; i >= 1; i--) begin
            step(0, 1, 0, 3'd4, 3'd6, 0, 0, 0, 0, 0, 0, 0);
            want = W'(i * 32'h100);
            checks++; if (pc !== want) begin
                errors++; $display("FAIL ras_pop%0d got %h want %h", i, pc, want);
            end
        end
        step(0, 1, 0, 3'd4, 3'd6, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (pc !== 32'h100 || misalign !== 1'b0 || ras_empty !== 1'b1) begin
            errors++; $display("FAIL ras_underflow got pc=%h mis=%b empty=%b want 100 0 1", pc, misalign, ras_empty);
        end
    endtask
`else
    task automatic test_no_ras();
        step(0, 1, 0, 3'd2, 3'd6, 0, 0, 0, 0, 0, 32'h300, 0);
        step(0, 1, 0, 3'd4, 3'd6, 0, 0, 1, 0, 0, 0, 0);
        checks++; if (pc !== 32'h300 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
            errors++; $display("FAIL no_ras got pc=%h e=%b f=%b err=%b want 300 1 0 0", pc, ras_empty, ras_full, ras_err);
        end
    endtask
`endif

    task automatic test_random();
        logic [2:0] bm;
        logic z, s;
        for (int n = 0; n < 400; n++) begin
            bm = 3'($urandom_range(0, 7));
            z = 1'($urandom); s = 1'($urandom);
            step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                 bm, z, s, 1'($urandom), $urandom, $urandom, $urandom, $urandom);
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got %h want %h", n, pc, m_pc); end
            checks++; if (pc_prev !== m_prev) begin errors++; $display("FAIL rnd_prev n=%0d got %h want %h", n, pc_prev, m_prev); end
            checks++; if (misalign !== m_mis) begin errors++; $display("FAIL rnd_mis n=%0d got %b want %b", n, misalign, m_mis); end
            checks++; if (br_taken !== ref_taken(bm, z, s)) begin
                errors++; $display("FAIL rnd_br n=%0d got %b want %b", n, br_taken, ref_taken(bm, z, s));
            end
            checks++; if (ras_empty !== (!HAS_RAS || m_stk.size() == 0) || ras_full !== (m_stk.size() == DEPTH)
                          || ras_err !== m_err) begin
                errors++; $display("FAIL rnd_ras n=%0d got e=%b f=%b err=%b want %b %b %b", n, ras_empty, ras_full,
                                   ras_err, (!HAS_RAS || m_stk.size() == 0), (m_stk.size() == DEPTH), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch_sweep();
        test_misalign();
`ifdef PC_RAS_EN
        test_ras();
`else
        test_no_ras();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
